charlcd_bus_driver: RTL

//  HD44780-class character-LCD bus timing engine. Downstream of the APB segment/char-LCD register block.

---
 rtl/charlcd_bus_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/charlcd_bus_driver.sv
// HD44780-class character-LCD write engine: runs the power-up init sequence, then
// sends one instruction/data byte per valid/ready handshake with fixed execution waits.
module charlcd_bus_driver #(
  parameter int T_POWERUP   = 150000,
  parameter int T_SETUP     = 2,
  parameter int T_EN_HIGH   = 5,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 400,
  parameter int T_EXEC_LONG = 16400,
  parameter int CNT_W       = 18
) (
  input  logic       LCDCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_LOAD, S_SETUP, S_EN_HI, S_HOLD, S_EXEC, S_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rom_byte;
  logic             long_wait;
  logic             timer_zero;

  always_comb begin
    rom_byte = 8'h0C;
    case (idx_q)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h08;
      3'd4:             rom_byte = 8'h01;
      3'd5:             rom_byte = 8'h06;
      default:          rom_byte = 8'h0C;
    endcase
  end

  // Clear/home and the very first init write need the long execution wait.
  assign long_wait  = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ||
                      (!init_done_q && idx_q == 3'd0);
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    if (!timer_zero) timer_d = timer_q - CNT_W'(1);

    case (state_q)
      // Timer resets to 0, so the power-up phase counts up instead of down.
      S_PWRUP: begin
        if (timer_q == LD_PWRUP) begin
          state_d = S_INIT_LOAD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_INIT_LOAD: begin
        state_d = S_SETUP;
        rs_d    = 1'b0;
        data_d  = rom_byte;
        timer_d = LD_SETUP;
      end
      S_SETUP: if (timer_zero) begin
        state_d = S_EN_HI;
        timer_d = LD_EN;
      end
      S_EN_HI: if (timer_zero) begin
        state_d = S_HOLD;
        timer_d = LD_HOLD;
      end
      S_HOLD: if (timer_zero) begin
        state_d = S_EXEC;
        timer_d = long_wait ? LD_LONG : LD_EXEC;
      end
      S_EXEC: if (timer_zero) begin
        if (init_done_q) begin
          state_d = S_IDLE;
        end else if (idx_q == 3'd6) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = S_INIT_LOAD;
          idx_d   = idx_q + 3'd1;
        end
      end
      S_IDLE: if (cmd_valid && ready_q) begin
        state_d = S_SETUP;
        rs_d    = cmd_rs;
        data_d  = cmd_data;
        timer_d = LD_SETUP;
      end
      default: state_d = S_PWRUP;
    endcase

    en_d    = (state_d == S_EN_HI);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_PWRUP;
      timer_q     <= '0;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign init_done = init_done_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;
  assign LCD_DATA  = data_q;

endmodule
